// File: rtl/iter_shifter.sv
// Iterative one-bit-per-cycle shifter/rotator with valid/ready handshakes.
// A request is latched in IDLE, shifted amt times in SHIFT, then held in DONE until taken.
module iter_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amt,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0]     M_SLL = 3'd0;
    localparam logic [2:0]     M_SRL = 3'd1;
    localparam logic [2:0]     M_SRA = 3'd2;
    localparam logic [2:0]     M_ROL = 3'd3;
    localparam logic [2:0]     M_ROR = 3'd4;
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [SHW-1:0]   cnt_q;
    logic [2:0]       mode_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // Single-bit step applied to the working register on every SHIFT cycle.
    always_comb begin
        work_d = work_q;
        case (mode_q)
            M_SLL:   work_d = {work_q[WIDTH-2:0], 1'b0};
            M_SRL:   work_d = {1'b0, work_q[WIDTH-1:1]};
            M_SRA:   work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            M_ROL:   work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            M_ROR:   work_d = {work_q[0], work_q[WIDTH-1:1]};
            default: work_d = work_q;
        endcase
    end

    // in_ready is registered so it stays low until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        work_q     <= data_in;
                        cnt_q      <= amt;
                        mode_q     <= mode;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if ((amt != '0) && (mode <= M_ROR)) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: an 8-bit default instance and a 16-bit/SHW=5
// instance for amounts at and beyond the data width.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8  = 1'b0;
    logic        in_ready8;
    logic [7:0]  data_in8   = '0;
    logic [2:0]  amt8       = '0;
    logic [2:0]  mode8      = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  data_out8;
    logic        busy8;

    logic        in_valid16  = 1'b0;
    logic        in_ready16;
    logic [15:0] data_in16   = '0;
    logic [4:0]  amt16       = '0;
    logic [2:0]  mode16      = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] data_out16;
    logic        busy16;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    iter_shifter u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .data_in  (data_in8),
        .amt      (amt8),
        .mode     (mode8),
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .data_out (data_out8),
        .busy     (busy8)
    );

    iter_shifter #(.WIDTH(16), .SHW(5)) u_dut16 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid16),
        .in_ready (in_ready16),
        .data_in  (data_in16),
        .amt      (amt16),
        .mode     (mode16),
        .out_valid(out_valid16),
        .out_ready(out_ready16),
        .data_out (data_out16),
        .busy     (busy16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs while busy, then check latency, result and handshake.
    task automatic run8(input string tag, input logic [7:0] d, input logic [2:0] m,
                        input logic [2:0] a, input logic [7:0] exp, input int unsigned exp_lat);
        int unsigned lat;
        chk({tag, "_rdy"}, 64'(in_ready8), 64'd1);
        in_valid8 = 1'b1; data_in8 = d; mode8 = m; amt8 = a;
        @(posedge clk); #1;
        data_in8 = ~d; mode8 = m ^ 3'd1; amt8 = ~a;
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid8 = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, 64'(data_out8), 64'(exp));
        chk({tag, "_busy"}, 64'(busy8), 64'd1);
        chk({tag, "_nrdy"}, 64'(in_ready8), 64'd0);
        if (out_ready8) begin
            @(posedge clk); #1;
            chk({tag, "_pulse"}, 64'(out_valid8), 64'd0);
            chk({tag, "_idle"}, 64'(in_ready8), 64'd1);
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] d, input logic [2:0] m,
                         input logic [4:0] a, input logic [15:0] exp, input int unsigned exp_lat);
        int unsigned lat;
        chk({tag, "_rdy"}, 64'(in_ready16), 64'd1);
        in_valid16 = 1'b1; data_in16 = d; mode16 = m; amt16 = a;
        @(posedge clk); #1;
        data_in16 = ~d; mode16 = m ^ 3'd2; amt16 = ~a;
        lat = 1;
        while (!out_valid16 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid16 = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, 64'(data_out16), 64'(exp));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(out_valid16), 64'd0);
        chk({tag, "_idle"}, 64'(in_ready16), 64'd1);
    endtask

    initial begin
        int unsigned seen;
        // Reset values while rst is held
        #3;
        chk("rst_data", 64'(data_out8), 64'd0);
        chk("rst_ov", 64'(out_valid8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_rdy", 64'(in_ready8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_rdy0", 64'(in_ready8), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_rdy1", 64'(in_ready8), 64'd1);

        run8("sll_b5_3", 8'hB5, 3'd0, 3'd3, 8'hA8, 4);
        run8("sra_96_7", 8'h96, 3'd2, 3'd7, 8'hFF, 8);
        run8("srl_96_7", 8'h96, 3'd1, 3'd7, 8'h01, 8);
        run8("rol_81_1", 8'h81, 3'd3, 3'd1, 8'h03, 2);
        run8("ror_81_7", 8'h81, 3'd4, 3'd7, 8'h03, 8);
        run8("ror_81_0", 8'h81, 3'd4, 3'd0, 8'h81, 1);
        run8("pass_5a", 8'h5A, 3'd5, 3'd3, 8'h5A, 1);
        run8("sra_40_2", 8'h40, 3'd2, 3'd2, 8'h10, 3);

        // Backpressure: hold 8'h0F in DONE for 10 cycles
        out_ready8 = 1'b0;
        run8("bp", 8'hF0, 3'd1, 3'd4, 8'h0F, 5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_ov", 64'(out_valid8), 64'd1);
            chk("bp_data", 64'(data_out8), 64'h0F);
            chk("bp_rdy", 64'(in_ready8), 64'd0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_ov", 64'(out_valid8), 64'd0);
        chk("bp_rel_rdy", 64'(in_ready8), 64'd1);

        // Reset asynchronously in the middle of a shift sequence
        in_valid8 = 1'b1; data_in8 = 8'hC3; mode8 = 3'd0; amt8 = 3'd7;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_data", 64'(data_out8), 64'd0);
        chk("abort_ov", 64'(out_valid8), 64'd0);
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_rdy", 64'(in_ready8), 64'd0);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        run8("after_abort", 8'h01, 3'd0, 3'd2, 8'h04, 3);

        // Amounts at and beyond WIDTH on the 16-bit instance
        run16("w16_sll_20", 16'h1234, 3'd0, 5'd20, 16'h0000, 21);
        run16("w16_sra_31", 16'h8001, 3'd2, 5'd31, 16'hFFFF, 32);
        run16("w16_sra_16", 16'h7FFF, 3'd2, 5'd16, 16'h0000, 17);
        run16("w16_srl_15", 16'hFFFF, 3'd1, 5'd15, 16'h0001, 16);
        run16("w16_rol_20", 16'h1234, 3'd3, 5'd20, 16'h2341, 21);
        run16("w16_ror_17", 16'h1234, 3'd4, 5'd17, 16'h091A, 18);
        run16("w16_rol_16", 16'h8000, 3'd3, 5'd16, 16'h8000, 17);
        run16("w16_pass", 16'hBEEF, 3'd6, 5'd9, 16'hBEEF, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 2..64.
REQ-002 Parameter SHW, default 3: shift-amount width; legal amounts are 0..2^SHW-1, and amounts >= WIDTH are legal.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 data_in  input  WIDTH  operand.
REQ-008 amt  input  SHW  shift amount.
REQ-009 mode  input  3  0=SLL, 1=SRL, 2=SRA, 3=ROL, 4=ROR, 5..7=pass-through.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 data_out  output  WIDTH  result, registered.
REQ-013 busy  output  1  high in SHIFT or DONE.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept on an edge with in_valid & in_ready: latch data_in into the working register, amt into the counter, mode into the mode register.
REQ-017 On accept with amt!=0 and mode<=4, the FSM SHALL go to SHIFT; otherwise it SHALL go straight to DONE with the working register equal to data_in.
REQ-018 Each SHIFT cycle SHALL shift by one bit and decrement the counter:
  - SLL: zero fill at LSB.
  - SRL: zero fill at MSB.
  - SRA: MSB replicated.
  - ROL / ROR: bit wraps to the opposite end.
REQ-019 On the edge where the counter goes from 1 to 0, the FSM SHALL enter DONE.
REQ-020 Latency: out_valid SHALL rise exactly amt+1 edges after the accept edge (1 edge when amt=0 or pass-through).
REQ-021 Amounts >= WIDTH SHALL be processed literally:
  - SLL/SRL give 0.
  - SRA gives all sign bits.
  - Rotates give the result for amt mod WIDTH.
REQ-022 data_out SHALL mirror the working register and SHALL hold stable throughout DONE until the handshake.
REQ-023 In DONE, out_valid & out_ready on an edge SHALL return the FSM to IDLE; otherwise it stays in DONE indefinitely (backpressure).
REQ-024 No new request SHALL be accepted on the same edge as a DONE handshake; the next accept is no earlier than the following edge.
REQ-025 in_valid, data_in, amt and mode SHALL be ignored outside IDLE; changing them mid-operation SHALL not affect the result.
REQ-026 Throughput: one result per amt+2 cycles when out_ready is tied high.

Reset
REQ-027 While rst=1, independent of clk, the block SHALL force:
  - state=IDLE
  - working register, counter and mode register = 0
  - data_out=0, out_valid=0, busy=0, in_ready=0.
REQ-028 After rst deasserts, in_ready SHALL be 1 from the first clock edge onward.
REQ-029 Reset asserted during SHIFT or DONE SHALL abort the operation; no result SHALL ever be presented for the aborted request.

Verification
REQ-030 WIDTH=8: data_in=8'hB5, mode=0, amt=3, out_ready=1 -> out_valid exactly 4 edges after accept, data_out=8'hA8, one-cycle pulse.
REQ-031 WIDTH=8: data_in=8'h96, mode=2, amt=7 -> data_out=8'hFF; same operand with mode=1 -> data_out=8'h01.
REQ-032 WIDTH=8: data_in=8'h81, mode=3 (ROL), amt=1 -> 8'h03; mode=4 (ROR), amt=7 -> 8'h03; amt=0 -> 8'h81 after 1 edge.
REQ-033 Backpressure: result 8'h0F held with out_ready=0 for 10 cycles -> out_valid and data_out stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Reset mid-SHIFT (amt=7, rst pulsed at cycle 3 between edges) -> outputs 0 immediately, no out_valid afterwards; next request 8'h01 with mode=0 and amt=2 -> 8'h04.
REQ-035 Random regression: WIDTH=16, SHW=5, all modes, random amt, data_in and out_ready -> every result matches the reference model, latency equals amt+1 edges, input changes while busy have no effect.
